fb_write_arbiter: RTL and testbench

//  Shares one single-port framebuffer RAM (160x240 pixels, 7-bit colour) between three requesters:
//   - the TIA pixel writer (vid_wr/vid_addr/vid_out), buffered in a small FIFO;
//   - the display scan-out reader, which has strict priority and fixed latency;
//   - an optional frame-clear engine.

---
 rtl/fb_pkg.sv | 7 +
 rtl/fb_pix_fifo.sv | 42 ++++
 rtl/fb_write_arbiter.sv | 98 +++++++++
 tb/tb_fb_write_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry and arbiter grant encoding
package fb_pkg;
    localparam int FB_W = 160;
    localparam int FB_H = 240;
    localparam int FB_PIXELS = FB_W * FB_H;
    typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_CLR, GNT_WR} gnt_e;
endpackage

// File: rtl/fb_pix_fifo.sv
// fb_pix_fifo: synchronous pixel FIFO; a push on full is taken only when a pop frees a slot
module fb_pix_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic wr_ok, rd_ok;
    assign rd_ok = pop && !empty;
    assign wr_ok = push && (!full || rd_ok);
    assign count = wptr - rptr;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = wptr == rptr;
    assign dout = mem[rptr[AW-1:0]];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + (AW+1)'(1);
            if (rd_ok) rptr <= rptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr_ok && !flush) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: RD > CLR > WR arbitration of a single-port framebuffer RAM.
// Define FB_CLEAR_EN to build the frame-clear engine.
module fb_write_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int FB_PIXELS = fb_pkg::FB_PIXELS,
    parameter logic [DATA_WIDTH-1:0] CLR_COLOR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pix_wr_i,
    input  logic [ADDR_WIDTH-1:0] pix_addr_i,
    input  logic [DATA_WIDTH-1:0] pix_data_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i,
    input  logic                  clr_start_i,
    output logic                  clr_busy_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    import fb_pkg::*;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FB_PIXELS - 1);
    gnt_e gnt;
    logic clr_busy, flush, pix_ok, full, empty, pop, rd_pend;
    logic [ADDR_WIDTH-1:0] clr_addr, q_addr;
    logic [DATA_WIDTH-1:0] q_data;
    logic [CW-1:0] unused_count;
    assign pix_ok = pix_wr_i && pix_addr_i <= LAST && !clr_busy;
    assign gnt = rd_req_i ? GNT_RD : clr_busy ? GNT_CLR : !empty ? GNT_WR : GNT_NONE;
    assign pop = gnt == GNT_WR;
    assign clr_busy_o = clr_busy;
    assign rd_data_o = mem_rdata_i;

    fb_pix_fifo #(.WIDTH(ADDR_WIDTH + DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (pix_ok),
        .pop   (pop),
        .flush (flush),
        .din   ({pix_addr_i, pix_data_i}),
        .dout  ({q_addr, q_data}),
        .full  (full),
        .empty (empty),
        .count (unused_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            mem_addr_o <= '0;
            mem_wdata_o <= '0;
            rd_pend <= 1'b0;
            rd_valid_o <= 1'b0;
            ovf_o <= 1'b0;
        end else begin
            mem_en_o <= gnt != GNT_NONE;
            mem_we_o <= gnt == GNT_CLR || gnt == GNT_WR;
            mem_addr_o <= gnt == GNT_RD ? rd_addr_i : gnt == GNT_CLR ? clr_addr : gnt == GNT_WR ? q_addr : '0;
            mem_wdata_o <= gnt == GNT_CLR ? CLR_COLOR : gnt == GNT_WR ? q_data : '0;
            rd_pend <= gnt == GNT_RD;
            rd_valid_o <= rd_pend;
            // a drop in the same cycle as a clear request wins
            ovf_o <= (pix_ok && full && !pop) || (ovf_o && !ovf_clr_i);
        end
    end

`ifdef FB_CLEAR_EN
    assign flush = clr_start_i && !clr_busy;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clr_busy <= 1'b0;
            clr_addr <= '0;
        end else if (flush) begin
            clr_busy <= 1'b1;
            clr_addr <= '0;
        end else if (gnt == GNT_CLR) begin
            clr_busy <= clr_addr != LAST;
            clr_addr <= clr_addr + ADDR_WIDTH'(1);
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_start_i;
    assign flush = 1'b0;
    assign clr_busy = 1'b0;
    assign clr_addr = '0;
`endif
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: random and directed stimulus against a queue-based reference model
module tb_fb_write_arbiter;
    localparam int NPIX = fb_pkg::FB_PIXELS;
    typedef struct packed {logic [15:0] a; logic [6:0] d;} pix_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic pix_wr_i, rd_req_i, ovf_clr_i, clr_start_i;
    logic [15:0] pix_addr_i, rd_addr_i;
    logic [6:0] pix_data_i;
    logic [6:0] rd_data_o, mem_wdata_o, mem_rdata_i;
    logic rd_valid_o, ovf_o, clr_busy_o, mem_en_o, mem_we_o;
    logic [15:0] mem_addr_o;

    fb_write_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pix_wr_i(pix_wr_i), .pix_addr_i(pix_addr_i), .pix_data_i(pix_data_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i),
        .clr_start_i(clr_start_i), .clr_busy_o(clr_busy_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // framebuffer RAM driven by the DUT
    bit [6:0] ram [NPIX];
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
            else mem_rdata_i <= ram[mem_addr_o];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: pixel queue, shadow framebuffer, expected RAM op per cycle
    bit [6:0] ref_mem [NPIX];
    pix_t q[$];
    bit e_en, e_we, e_rv, op_rd, m_ovf, m_busy;
    logic [15:0] e_addr;
    logic [6:0] e_wdata, e_rd, op_rdata;
    int m_caddr;

    task automatic model_step();
        bit busy0, drop;
        pix_t ent;
        if (!rst_ni) begin
            q.delete();
            {e_en, e_we, e_rv, op_rd, m_ovf, m_busy} = '0;
            m_caddr = 0;
            return;
        end
        e_rv = op_rd;
        e_rd = op_rdata;
        busy0 = m_busy;
        op_rd = 1'b0;
        e_en = 1'b1;
        e_we = 1'b0;
        if (rd_req_i) begin
            op_rd = 1'b1;
            e_addr = rd_addr_i;
            op_rdata = ref_mem[rd_addr_i];
        end else if (m_busy) begin
            e_we = 1'b1;
            e_addr = 16'(m_caddr);
            e_wdata = 7'h00;
            ref_mem[m_caddr] = 7'h00;
            if (m_caddr == NPIX - 1) m_busy = 1'b0;
            m_caddr++;
        end else if (q.size() > 0) begin
            ent = q.pop_front();
            e_we = 1'b1;
            e_addr = ent.a;
            e_wdata = ent.d;
            ref_mem[ent.a] = ent.d;
        end else e_en = 1'b0;
        drop = 1'b0;
        if (pix_wr_i && int'(pix_addr_i) < NPIX && !busy0) begin
            if (q.size() < 4) q.push_back('{pix_addr_i, pix_data_i});
            else drop = 1'b1;
        end
        m_ovf = drop ? 1'b1 : ovf_clr_i ? 1'b0 : m_ovf;
`ifdef FB_CLEAR_EN
        if (clr_start_i && !busy0) begin
            q.delete();
            m_busy = 1'b1;
            m_caddr = 0;
        end
`endif
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_step();
        #1;
        check("mem_en", mem_en_o, e_en);
        check("mem_we", mem_we_o, e_we);
        if (e_en) check("mem_addr", mem_addr_o, e_addr);
        if (e_we) check("mem_wdata", mem_wdata_o, e_wdata);
        check("rd_valid", rd_valid_o, e_rv);
        if (e_rv) check("rd_data", rd_data_o, e_rd);
        check("ovf", ovf_o, m_ovf);
        check("clr_busy", clr_busy_o, m_busy);
    endtask

    task automatic idle();
        {pix_wr_i, rd_req_i, ovf_clr_i, clr_start_i} = '0;
        pix_addr_i = '0;
        rd_addr_i = '0;
        pix_data_i = '0;
    endtask

    initial begin
        int nw;
        rst_ni = 1'b0;
        idle();
        repeat (3) cycle();
        check("rst_en", mem_en_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_rv", rd_valid_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_busy", clr_busy_o, 0);
        @(negedge clk_i) rst_ni = 1'b1;

        // single read of a pixel written first
        pix_wr_i = 1'b1; pix_addr_i = 16'd100; pix_data_i = 7'h2A;
        cycle();
        idle();
        repeat (3) cycle();
        rd_req_i = 1'b1; rd_addr_i = 16'd100;
        cycle();
        idle();
        check("t1_en", mem_en_o, 1);
        check("t1_we", mem_we_o, 0);
        cycle();
        check("t1_valid", rd_valid_o, 1);
        check("t1_data", rd_data_o, 7'h2A);

        // four back-to-back pixels
        for (int i = 0; i < 4; i++) begin
            pix_wr_i = 1'b1; pix_addr_i = 16'(i); pix_data_i = 7'(i + 5);
            cycle();
        end
        idle();
        repeat (6) cycle();
        check("t2_ovf", ovf_o, 0);

        // reads starve writes, fifth pixel overflows
        rd_req_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_addr_i = 16'(i * 7);
            pix_wr_i = i < 5;
            pix_addr_i = 16'(200 + i);
            pix_data_i = 7'(i + 1);
            cycle();
        end
        idle();
        check("t3_ovf_set", ovf_o, 1);
        repeat (8) cycle();
        ovf_clr_i = 1'b1;
        cycle();
        idle();
        check("t3_ovf_clr", ovf_o, 0);

        // out-of-range pixel
        pix_wr_i = 1'b1; pix_addr_i = 16'(NPIX); pix_data_i = 7'h11;
        cycle();
        idle();
        check("t4_en", mem_en_o, 0);
        repeat (3) cycle();
        check("t4_ovf", ovf_o, 0);

`ifdef FB_CLEAR_EN
        clr_start_i = 1'b1;
        cycle();
        idle();
        nw = 0;
        for (int i = 0; i < NPIX + 20; i++) begin
            rd_req_i = i == 20000;
            rd_addr_i = 16'd5;
            pix_wr_i = i < 38000 && i % 5 == 0;
            pix_addr_i = 16'(i % 64);
            pix_data_i = 7'(i | 1);
            cycle();
            if (mem_en_o && mem_we_o) nw++;
        end
        idle();
        check("t5_writes", nw, NPIX);
        check("t5_busy", clr_busy_o, 0);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rd_req_i = $urandom % 3 == 0;
            rd_addr_i = 16'($urandom_range(0, 63));
            pix_wr_i = $urandom % 2 == 0;
            pix_addr_i = $urandom % 8 == 0 ? 16'($urandom_range(NPIX, 65535)) : 16'($urandom_range(0, 63));
            pix_data_i = 7'($urandom);
            ovf_clr_i = $urandom % 16 == 0;
`ifdef FB_CLEAR_EN
            clr_start_i = 1'b0;
`else
            clr_start_i = $urandom % 32 == 0;
`endif
            cycle();
        end
        idle();
        repeat (10) cycle();

        // reset while the queue drains
        rd_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr_i = 16'(i);
            pix_wr_i = 1'b1; pix_addr_i = 16'(300 + i); pix_data_i = 7'(i + 9);
            cycle();
        end
        idle();
        cycle();
        #2 rst_ni = 1'b0;
        #1;
        check("t6_en", mem_en_o, 0);
        check("t6_we", mem_we_o, 0);
        repeat (3) cycle();
        @(negedge clk_i) rst_ni = 1'b1;
        repeat (6) cycle();
        check("t6_nowr", mem_we_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
